truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Parametrised, synthesizable stimulus-and-check engine for small combinational blocks with N_IN inputs and one output.
- On `start`, drives every input combination onto `dut_in` in ascending binary order, holding each for HOLD cycles.
- At the end of each hold window, samples `dut_y` and compares it against the EXPECTED truth table.
- Reports the pass/fail result, the mismatch count and the first failing vector.
- Replaces hand-written exhaustive-vector benches; usable on-board (LEDs) or in simulation.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8.
- HOLD, 10, cycles each vector is held; legal range >= 1.
- EXPECTED, 8'hE8, expected output per vector; bit v = expected y for `dut_in`==v; width 2**N_IN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a sweep; honoured only in IDLE or DONE.
- dut_in  out  N_IN  stimulus vector to the DUT.
- dut_y  in  1  DUT output.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until the next accepted start or reset.
- pass  out  1  valid when done=1; high iff err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep.
- first_err_valid  out  1  at least one mismatch recorded this sweep.
- first_err_idx  out  N_IN  lowest vector index that mismatched.

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): FSM enters IDLE; every output is 0 (`dut_in`, `busy`, `done`, `pass`, `err_count`, `first_err_valid`, `first_err_idx`).
- Reset mid-sweep aborts the sweep immediately; `done` does not assert.
- FSM states: IDLE, DRIVE, DONE.
- IDLE --start=1--> DRIVE.
  - Same edge: vector v=0, hold counter h=0, `err_count`=0, `first_err_valid`=0, `first_err_idx`=0, `done`=0, `pass`=0.
- DRIVE:
  - `busy`=1, `dut_in`=v.
  - Each cycle h increments.
  - At the edge where h==HOLD-1, `dut_y` is sampled and compared with EXPECTED[v].
  - Mismatch (including X/Z in simulation, i.e. case-inequality) increments `err_count`.
  - If `first_err_valid`==0 on a mismatch, `first_err_idx`<=v and `first_err_valid`<=1.
  - Same edge: if v==2**N_IN-1, go to DONE; else v<=v+1, h<=0.
- HOLD==1: every cycle is a sample cycle.
- DONE:
  - `busy`=0, `done`=1, `pass`=(`err_count`==0).
  - `dut_in` holds 0.
  - Results hold until `start`=1, which re-enters DRIVE exactly as from IDLE.
- `start` while `busy`=1 is ignored; `start` held high continuously restarts a sweep on the cycle after each completion.
- Timing: `busy` rises the cycle after `start` is accepted; `done` rises exactly 2**N_IN*HOLD cycles after `busy` rises; `busy` falls the same cycle `done` rises.
- Width: `err_count` max is 2**N_IN, which fits N_IN+1 bits, so no saturation logic is needed.
- v is N_IN bits; the terminal test on v==2**N_IN-1 prevents wrap.

Optional Feature:
- Macro TTS_CAPTURE_EN.
- Defined:
  - Adds output port `observed_tt` [2**N_IN-1:0]; bit v is loaded with the sampled `dut_y` at v's sample edge.
  - `observed_tt` is cleared to 0 on reset and on an accepted start.
  - `observed_tt`==EXPECTED iff `pass` (for X-free `dut_y`).
- Undefined: no port and no capture register; all other behaviour is identical.

Decomposition:
- Package tts_pkg:
  - `state_t` enum {IDLE, DRIVE, DONE}.
  - Function `num_vec`(n) = 2**n.
  - Localparam HOLD_W = $clog2(HOLD)+1.
- Sub-module tts_hold_timer:
  - Counts 0..HOLD-1.
  - `clr` input; `last` output flags h==HOLD-1.
  - Top-level FSM uses `last` as the sample/advance strobe.

Test Plan:
- Defaults (N_IN=3, HOLD=10, EXPECTED=8'hE8), DUT = majority(a,b,c): pulse `start` → `busy` high 80 cycles; `dut_in` steps 0..7 every 10 cycles; `done`=1, `pass`=1, `err_count`=0, `first_err_valid`=0.
- Same setup, DUT output stuck-at-0: `err_count`=4, `pass`=0, `first_err_idx`=3, `first_err_valid`=1.
- N_IN=2, HOLD=1, EXPECTED=4'b0110, DUT = XOR: `done` exactly 4 cycles after `busy` rises, `pass`=1; then DUT swapped to OR, restart → `err_count`=1, `first_err_idx`=3.
- Reset mid-sweep: `rst_n`=0 at vector 5 → next cycle all outputs 0, FSM in IDLE; a new `start` runs a full 80-cycle sweep with fresh results.
- `start` pulsed while `busy` at vector 2 → ignored; sweep timing unchanged. `start` in DONE → `done` drops, results clear, new sweep begins.
- With TTS_CAPTURE_EN and the majority DUT: `observed_tt`==8'hE8 at `done`. With the stuck-at-0 DUT: `observed_tt`==8'h00.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types and sizing helpers for the truth_table_sweeper block.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int HOLD_DEF = 10;
  localparam int HOLD_W   = $clog2(HOLD_DEF) + 1;

  // Number of input combinations for an n-input block.
  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

  // Hold-counter width for an arbitrary HOLD; stays >= 1 bit even for HOLD==1.
  function automatic int hold_w(input int hold);
    return $clog2(hold) + 1;
  endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Hold-window counter: counts 0..HOLD-1 while enabled and flags the last cycle.
module tts_hold_timer
  import tts_pkg::*;
#(
  parameter int HOLD = HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int            HW     = hold_w(HOLD);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);

  logic [HW-1:0] h_q, h_d;

  assign last = (h_q == H_LAST);

  always_comb begin
    // NOTE: default first so every path assigns h_d and no latch is inferred.
    h_d = h_q;
    if (clr) begin
      h_d = '0;
    end else if (en) begin
      h_d = last ? '0 : h_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register updates
    // from pre-edge values regardless of process ordering.
    if (!rst_n) begin
      h_q <= '0;
    end else begin
      h_q <= h_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table stimulus/check engine for an N_IN-input, 1-output block.
// Define TTS_CAPTURE_EN to add the observed_tt capture register and port.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int                        N_IN     = 3,
  parameter int                        HOLD     = 10,
  parameter logic [num_vec(N_IN)-1:0]  EXPECTED = 8'hE8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_y,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [N_IN:0]             err_count,
  output logic                      first_err_valid,
  output logic [N_IN-1:0]           first_err_idx
`ifdef TTS_CAPTURE_EN
  ,
  output logic [num_vec(N_IN)-1:0]  observed_tt
`endif
);

  localparam int              NV     = num_vec(N_IN);
  localparam int              ERR_W  = N_IN + 1;
  localparam logic [N_IN-1:0] V_LAST = N_IN'(NV - 1);

  state_t             state_q, state_d;
  logic [N_IN-1:0]    v_q, v_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [N_IN-1:0]    fei_q, fei_d;
  logic               timer_clr;
  logic               sample;
  logic               mismatch;
`ifdef TTS_CAPTURE_EN
  logic [NV-1:0]      obs_q, obs_d;
`endif

  tts_hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (state_q == DRIVE),
    .last  (sample)
  );

  // Case-inequality so an X/Z from the block under test counts as a failure.
  assign mismatch = (dut_y !== EXPECTED[v_q]);

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fei_d     = fei_q;
    timer_clr = 1'b0;
`ifdef TTS_CAPTURE_EN
    obs_d     = obs_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          v_d       = '0;
          err_d     = '0;
          fev_d     = 1'b0;
          fei_d     = '0;
          timer_clr = 1'b1;
`ifdef TTS_CAPTURE_EN
          obs_d     = '0;
`endif
        end
      end
      DRIVE: begin
        if (sample) begin
          if (mismatch) begin
            err_d = err_q + ERR_W'(1);
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = v_q;
            end
          end
`ifdef TTS_CAPTURE_EN
          obs_d[v_q] = dut_y;
`endif
          // v returns to 0 on completion so dut_in idles low in DONE.
          if (v_q == V_LAST) begin
            state_d = DONE;
            v_d     = '0;
          end else begin
            v_d = v_q + N_IN'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
`ifdef TTS_CAPTURE_EN
      obs_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
`ifdef TTS_CAPTURE_EN
      obs_q   <= obs_d;
`endif
    end
  end

  assign dut_in          = v_q;
  assign busy            = (state_q == DRIVE);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
`ifdef TTS_CAPTURE_EN
  assign observed_tt     = obs_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (3-input/HOLD 10
// and 2-input/HOLD 1) driven by a truth-table-programmable behavioural device.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  int         sel;
  logic [7:0] dev_tt;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 1: defaults, N_IN=3, HOLD=10, EXPECTED=8'hE8 (majority)
  logic [2:0] din1, fei1;
  logic [3:0] err1;
  logic       busy1, done1, pass1, fev1, dut_y1, start1;
  // Instance 2: N_IN=2, HOLD=1, EXPECTED=4'b0110 (xor)
  logic [1:0] din2, fei2;
  logic [2:0] err2;
  logic       busy2, done2, pass2, fev2, dut_y2, start2;
`ifdef TTS_CAPTURE_EN
  logic [7:0] obs1;
  logic [3:0] obs2;
`endif

  always #5 clk = ~clk;

  assign start1 = start && (sel == 0);
  assign start2 = start && (sel == 1);
  assign dut_y1 = dev_tt[din1];
  assign dut_y2 = dev_tt[din2];

  truth_table_sweeper u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start1),
    .dut_in          (din1),
    .dut_y           (dut_y1),
    .busy            (busy1),
    .done            (done1),
    .pass            (pass1),
    .err_count       (err1),
    .first_err_valid (fev1),
    .first_err_idx   (fei1)
`ifdef TTS_CAPTURE_EN
    ,
    .observed_tt     (obs1)
`endif
  );

  truth_table_sweeper #(
    .N_IN     (2),
    .HOLD     (1),
    .EXPECTED (4'b0110)
  ) u_dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start2),
    .dut_in          (din2),
    .dut_y           (dut_y2),
    .busy            (busy2),
    .done            (done2),
    .pass            (pass2),
    .err_count       (err2),
    .first_err_valid (fev2),
    .first_err_idx   (fei2)
`ifdef TTS_CAPTURE_EN
    ,
    .observed_tt     (obs2)
`endif
  );

  // Selected-instance view used by the generic sweep task.
  int busy_m, done_m, pass_m, err_m, fev_m, fei_m, din_m, hold_m, nvec_m, obs_m;
  always_comb begin
    if (sel == 0) begin
      busy_m = int'(busy1); done_m = int'(done1); pass_m = int'(pass1);
      err_m  = int'(err1);  fev_m  = int'(fev1);  fei_m  = int'(fei1);
      din_m  = int'(din1);  hold_m = 10;          nvec_m = 8;
`ifdef TTS_CAPTURE_EN
      obs_m  = int'(obs1);
`else
      obs_m  = 0;
`endif
    end else begin
      busy_m = int'(busy2); done_m = int'(done2); pass_m = int'(pass2);
      err_m  = int'(err2);  fev_m  = int'(fev2);  fei_m  = int'(fei2);
      din_m  = int'(din2);  hold_m = 1;           nvec_m = 4;
`ifdef TTS_CAPTURE_EN
      obs_m  = int'(obs2);
`else
      obs_m  = 0;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: mismatches are the set bits of (device table XOR expected table).
  function automatic void model(input int s, input logic [7:0] tt,
                                output int err, output int fei, output bit fev);
    logic [7:0] exp_tt;
    int         n;
    exp_tt = (s == 0) ? 8'hE8 : 8'h06;
    n      = (s == 0) ? 8 : 4;
    err = 0; fei = 0; fev = 1'b0;
    for (int v = 0; v < n; v++) begin
      if (tt[v] != exp_tt[v]) begin
        err++;
        if (!fev) begin
          fev = 1'b1;
          fei = v;
        end
      end
    end
  endfunction

  // Runs one sweep on instance s with device table tt; optionally pokes start
  // while busy at cycle index poke (relative to busy rising).
  task automatic sweep(input int s, input logic [7:0] tt, input int poke,
                       input int exp_err, input int exp_fei, input bit exp_fev);
    int k, bad;
    sel    = s;
    dev_tt = tt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("accept_busy", busy_m, 1);
    check("accept_done", done_m, 0);
    check("accept_err_clear", err_m, 0);
    check("accept_fev_clear", fev_m, 0);
    k = 0; bad = 0;
    while (busy_m == 1 && k < 2000) begin
      if (din_m != k / hold_m) bad++;
      start = (k == poke);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_length", k, nvec_m * hold_m);
    check("dut_in_sequence_errs", bad, 0);
    check("done_at_end", done_m, 1);
    check("pass", pass_m, (exp_err == 0) ? 1 : 0);
    check("err_count", err_m, exp_err);
    check("first_err_valid", fev_m, int'(exp_fev));
    check("first_err_idx", fei_m, exp_fei);
    check("dut_in_idle_zero", din_m, 0);
`ifdef TTS_CAPTURE_EN
    check("observed_tt", obs_m, int'(tt & ((s == 0) ? 8'hFF : 8'h0F)));
`endif
  endtask

  typedef struct {
    int         s;
    logic [7:0] tt;
    int         err;
    int         fei;
    bit         fev;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int k, e_err, e_fei, s;
    bit e_fev;
    logic [7:0] tt;

    tbl[0] = '{0, 8'hE8, 0, 0, 1'b0};  // majority device
    tbl[1] = '{0, 8'h00, 4, 3, 1'b1};  // stuck-at-0
    tbl[2] = '{0, 8'hFF, 4, 0, 1'b1};  // stuck-at-1
    tbl[3] = '{0, 8'hE9, 1, 0, 1'b1};  // lowest vector wrong
    tbl[4] = '{0, 8'h68, 1, 7, 1'b1};  // only last vector wrong
    tbl[5] = '{0, 8'h17, 8, 0, 1'b1};  // inverted: max error count
    tbl[6] = '{1, 8'h06, 0, 0, 1'b0};  // xor device on xor table
    tbl[7] = '{1, 8'h0E, 1, 3, 1'b1};  // or device on xor table
    tbl[8] = '{1, 8'h09, 4, 0, 1'b1};  // xnor: every vector wrong

    rst_n = 1'b0; start = 1'b0; sel = 0; dev_tt = 8'hE8;
    repeat (3) @(negedge clk);
    check("rst1_busy", int'(busy1), 0);
    check("rst1_done", int'(done1), 0);
    check("rst1_pass", int'(pass1), 0);
    check("rst1_err", int'(err1), 0);
    check("rst1_din", int'(din1), 0);
    check("rst2_done", int'(done2), 0);
    check("rst2_err", int'(err2), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      sweep(tbl[i].s, tbl[i].tt, -1, tbl[i].err, tbl[i].fei, tbl[i].fev);

    // start pulsed at vector 2 while busy must not disturb the sweep.
    sweep(0, 8'hE8, 25, 0, 0, 1'b0);

    // Reset mid-sweep with the stuck-at-0 device, then a fresh full sweep.
    sel = 0; dev_tt = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (din1 != 3'd5 && k < 200) begin
      k++;
      @(negedge clk);
    end
    check("reach_vector5", int'(din1), 5);
    check("pre_reset_err", int'(err1), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy1), 0);
    check("midrst_done", int'(done1), 0);
    check("midrst_pass", int'(pass1), 0);
    check("midrst_din", int'(din1), 0);
    check("midrst_err", int'(err1), 0);
    check("midrst_fev", int'(fev1), 0);
    check("midrst_fei", int'(fei1), 0);
`ifdef TTS_CAPTURE_EN
    check("midrst_obs", int'(obs1), 0);
`endif
    rst_n = 1'b1;
    sweep(0, 8'hE8, -1, 0, 0, 1'b0);

    // start held high: restart on the cycle after completion.
    sel = 1; dev_tt = 8'h06; start = 1'b1;
    k = 0;
    while (!done2 && k < 50) begin
      k++;
      @(negedge clk);
    end
    check("cont_done", int'(done2), 1);
    check("cont_pass", int'(pass2), 1);
    @(negedge clk);
    check("cont_restart_busy", int'(busy2), 1);
    check("cont_restart_done", int'(done2), 0);
    start = 1'b0;
    k = 0;
    while (!done2 && k < 50) begin
      k++;
      @(negedge clk);
    end
    check("cont_done_again", int'(done2), 1);

    // Random device tables against the reference model.
    for (int i = 0; i < 10; i++) begin
      s  = int'($urandom_range(0, 1));
      tt = 8'($urandom);
      model(s, tt, e_err, e_fei, e_fev);
      sweep(s, tt, int'($urandom_range(0, 40)), e_err, e_fei, e_fev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
